// File: rtl/game_tick_gen.sv
// Frame-rate divided tick generator. It detects end-of-frame from the scan position and
// drives a set of independently divided one-cycle update ticks, with pause and single-step.
module game_tick_gen #(
  parameter int X_W     = 10,
  parameter int Y_W     = 10,
  parameter int X_LAST  = 39,
  parameter int Y_LAST  = 29,
  parameter int NUM_CH  = 2,
  parameter int DIV_W   = 3,
  parameter int DEF_DIV = 4,
  parameter int FC_W    = 8
) (
  input  logic                    in_clk,
  input  logic                    rst,
  input  logic [X_W-1:0]          x_in,
  input  logic [Y_W-1:0]          y_in,
  input  logic                    run,
  input  logic                    step,
  input  logic [NUM_CH-1:0]       cfg_load,
  input  logic [NUM_CH*DIV_W-1:0] div_in,
  output logic                    frame_strobe,
  output logic [FC_W-1:0]         frame_count,
  output logic [NUM_CH-1:0]       tick_out,
  output logic [NUM_CH*DIV_W-1:0] div_q
);

  logic match;
  logic at_last_q;
  logic ev;

  assign match = (x_in == X_W'(X_LAST)) && (y_in == Y_W'(Y_LAST));
  // at_last_q resets high so a position parked on the last cell at reset release is not a new frame.
  assign ev    = match & ~at_last_q;

  always_ff @(posedge in_clk) begin
    if (rst) begin
      at_last_q    <= 1'b1;
      frame_strobe <= 1'b0;
      frame_count  <= '0;
    end else begin
      at_last_q    <= match;
      frame_strobe <= ev;
      if (ev) begin
        frame_count <= frame_count + FC_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] cnt_r;
    logic             tick_r;

    always_ff @(posedge in_clk) begin
      if (rst) begin
        div_r  <= DIV_W'(DEF_DIV);
        cnt_r  <= '0;
        tick_r <= 1'b0;
      end else begin
        tick_r <= 1'b0;
        if (cfg_load[i]) begin
          // A load restarts the channel and suppresses any coincident tick.
          div_r <= div_in[i*DIV_W +: DIV_W];
          cnt_r <= '0;
        end else if (div_r == '0) begin
          cnt_r <= '0;
        end else if (run) begin
          if (ev) begin
            // >= lets a counter stranded above a lowered divisor fire on the next frame.
            if (cnt_r >= div_r - DIV_W'(1)) begin
              tick_r <= 1'b1;
              cnt_r  <= '0;
            end else begin
              cnt_r <= cnt_r + DIV_W'(1);
            end
          end
        end else if (step) begin
          tick_r <= 1'b1;
          cnt_r  <= '0;
        end
      end
    end

    assign div_q[i*DIV_W +: DIV_W] = div_r;
    assign tick_out[i]             = tick_r;
  end

endmodule

// File: doc/game_tick_gen.md
Name: game_tick_gen

Overview:
- Parametrised multi-channel game-state update tick generator, driven by the scan position from the VGA/display timing block.
- Detects end-of-frame, i.e. the first sampled cycle where the position equals (X_LAST, Y_LAST).
- Each channel divides the frame rate by its own runtime-programmable divisor. Each channel emits a one-cycle tick for its consumer: snake/player movement, enemy logic, animation.
- Adds pause, single-step, runtime divisor load and a frame counter.

Parameters:
X_W, 10, width of x_in
Y_W, 10, width of y_in
X_LAST, 39, x coordinate of last drawn cell
Y_LAST, 29, y coordinate of last drawn cell
NUM_CH, 2, number of independent tick channels
DIV_W, 3, width of each channel divisor
DEF_DIV, 4, per-channel divisor after reset
FC_W, 8, width of frame counter

Ports:
in_clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-high reset
x_in  input  X_W  current scan x coordinate
y_in  input  Y_W  current scan y coordinate
run  input  1  1 = ticks enabled, 0 = paused
step  input  1  one-cycle pulse; forces one tick per enabled channel while paused
cfg_load  input  NUM_CH  per-channel load strobe for divisor
div_in  input  NUM_CH*DIV_W  divisor for channel i in bits [i*DIV_W +: DIV_W]
frame_strobe  output  1  one-cycle pulse per completed frame
frame_count  output  FC_W  completed-frame counter, wraps
tick_out  output  NUM_CH  per-channel one-cycle update pulse
div_q  output  NUM_CH*DIV_W  currently active divisors, readback

Behaviour:
- Reset is synchronous and active-high (rst sampled on rising in_clk). While rst is high:
  - frame_strobe=0, tick_out=0, frame_count=0.
  - All channel counters=0.
  - div_q = DEF_DIV in every channel.
  - at_last_q=1, so no frame event is generated if the position sits on the last cell at reset release.
  - Reset mid-frame or mid-count discards all progress.
- Frame detect:
  - match = (x_in==X_LAST)&&(y_in==Y_LAST).
  - at_last_q <= match every cycle.
  - Frame event ev = match & ~at_last_q. This gives exactly one event per frame, even when the position holds for many in_clk cycles.
- frame_strobe is a registered copy of ev: high for exactly 1 cycle, on the edge after the first matching sample.
- frame_count increments by 1 on ev and wraps from 2^FC_W-1 to 0. It counts regardless of run.
- Per channel i, with D = div_q[i]:
  - D=0: channel disabled. It never ticks, step included, and its counter holds 0.
  - cfg_load[i]: div_q[i] <= div_in slice and cnt[i] <= 0. No tick on channel i this cycle, even if ev or step coincides. Other channels are unaffected.
  - Else, when run=1 and ev: if cnt[i] >= D-1, tick_out[i] <= 1 and cnt[i] <= 0; otherwise cnt[i] <= cnt[i]+1.
    - The >= comparison means a counter left above a newly lowered divisor ticks on the next event.
  - When run=0: ev does not change cnt[i] and produces no tick.
    - step=1 gives tick_out[i] <= 1 and cnt[i] <= 0.
    - step and ev in the same paused cycle give exactly one tick.
  - When run=1: step is ignored.
  - tick_out[i] is high for 1 cycle only; it is deasserted on every other cycle.
- Latency: tick_out and frame_strobe assert together, 1 cycle after the first matching x/y sample.
- Ticks are never issued back-to-back from a single frame.
- run toggling mid-count preserves cnt[i]. Counting resumes where it stopped.
- D=1 ticks every frame. D = 2^DIV_W-1 is the maximum period.

Test Plan:
- Reset then defaults (DEF_DIV=4), run=1, position held at (39,29) for 5 cycles per frame over 8 frames -> frame_strobe 8 single-cycle pulses; tick_out[0] and [1] pulse on frames 4 and 8 only; frame_count=8.
- Position at (39,29) when rst deasserts -> no frame_strobe and no tick until the position leaves and returns; frame_count stays 0.
- cfg_load[1]=1 with div_in ch1=1, ch0 unchanged -> ch1 ticks every frame starting from the next event; ch0 keeps its 4-frame cadence; div_q readback shows ch1=1.
- After 3 events with D=4 (cnt=3), load D=2 on ch0 -> cnt cleared, no tick that cycle, ticks on the 2nd following event; repeat the load coincident with ev -> no tick that cycle.
- run=0 over 5 frames -> frame_strobe and frame_count keep advancing, tick_out stays 0. Then step pulse -> one tick on each enabled channel; step coincident with ev -> single tick. run=1 with step -> step ignored.
- Load D=0 on ch0 -> ch0 never ticks over 10 frames or on step while paused; ch1 unaffected. frame_count with FC_W=8 wraps 255->0 after 256 frames.
